oled_ctrl: RTL and testbench

Top-level sequencer for the SSD1306 OLED panel. It powers the panel up (VDD, reset pulse, VBAT), releases the `oled_init` command block and shares the single SPI byte sender with it. After init it streams framebuffer pages to the panel on request. It sits between the SPI byte sender, the `oled_init` block and the framebuffer read port.

---
 rtl/oled_pkg.sv | 37 +++
 rtl/oled_frame_writer.sv | 186 ++++++++++++++++++
 rtl/oled_ctrl.sv | 173 +++++++++++++++++
 tb/tb_oled_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 OLED controller slice.
package oled_pkg;

  // Top-level sequencer states. A frame in progress is one state here;
  // its command/fetch/data walk is tracked inside oled_frame_writer.
  typedef enum logic [2:0] {
    ST_VDD_WAIT  = 3'd0,
    ST_RST_LOW   = 3'd1,
    ST_RST_REC   = 3'd2,
    ST_VBAT_WAIT = 3'd3,
    ST_INIT      = 3'd4,
    ST_IDLE      = 3'd5,
    ST_FRAME     = 3'd6
  } oled_state_e;

  // Frame walk states.
  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_CMD   = 2'd1,
    WR_FETCH = 2'd2,
    WR_DATA  = 2'd3
  } wr_state_e;

  localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
  localparam logic [7:0] CMD_COL_LO    = 8'h00;
  localparam logic [7:0] CMD_COL_HI    = 8'h10;

  localparam int DEF_PAGES = 4;
  localparam int DEF_COLS  = 128;
  localparam int DLY_W     = 24;

  // Page-address command byte for a given page number.
  function automatic logic [7:0] page_cmd(input logic [7:0] page);
    return CMD_PAGE_BASE | page;
  endfunction

endpackage

// File: rtl/oled_frame_writer.sv
// Walks one frame: per page three address commands, then COLS data bytes
// fetched from the framebuffer (1-cycle read latency). All outputs
// registered except last_done, which tells the sequencer the final byte
// was accepted this cycle.
module oled_frame_writer
  import oled_pkg::*;
#(
  parameter int PAGES = DEF_PAGES,
  parameter int COLS  = DEF_COLS,
  localparam int AW = $clog2(PAGES * COLS),
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          spi_send_done,
  input  logic [7:0]    fb_data,
  output logic [AW-1:0] fb_addr,
  output logic          spi_send,
  output logic [7:0]    spi_data,
  output logic          spi_dc,
  output logic          frame_done,
  output logic          last_done
);

  wr_state_e       state_r, state_s;
  logic [PW-1:0]   page_r, page_s, page_inc_s;
  logic [CW-1:0]   col_r, col_s;
  logic [1:0]      cmd_idx_r, cmd_idx_s;
  logic            fetch_r, fetch_s;
  logic [AW-1:0]   addr_r, addr_s;
  logic            send_r, send_s;
  logic [7:0]      data_r, data_s;
  logic            dc_r, dc_s;
  logic            fd_r, fd_s;
  logic            done_s, col_last_s, page_last_s;

  // A done pulse only counts while a byte is actually being requested.
  assign done_s      = spi_send_done & send_r;
  assign col_last_s  = (col_r == CW'(COLS - 1));
  assign page_last_s = (page_r == PW'(PAGES - 1));
  assign page_inc_s  = page_r + PW'(1);
  assign last_done   = (state_r == WR_DATA) & done_s & col_last_s & page_last_s;

  assign fb_addr    = addr_r;
  assign spi_send   = send_r;
  assign spi_data   = data_r;
  assign spi_dc     = dc_r;
  assign frame_done = fd_r;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= WR_IDLE;
      page_r    <= '0;
      col_r     <= '0;
      cmd_idx_r <= 2'd0;
      fetch_r   <= 1'b0;
      addr_r    <= '0;
      send_r    <= 1'b0;
      data_r    <= 8'h00;
      dc_r      <= 1'b0;
      fd_r      <= 1'b0;
    end else begin
      state_r   <= state_s;
      page_r    <= page_s;
      col_r     <= col_s;
      cmd_idx_r <= cmd_idx_s;
      fetch_r   <= fetch_s;
      addr_r    <= addr_s;
      send_r    <= send_s;
      data_r    <= data_s;
      dc_r      <= dc_s;
      fd_r      <= fd_s;
    end
  end

  // Next-state selection for the frame walk.
  always_comb begin
    state_s = state_r;
    case (state_r)
      WR_IDLE: begin
        if (start) state_s = WR_CMD;
        else       state_s = WR_IDLE;
      end
      WR_CMD: begin
        if (done_s && (cmd_idx_r >= 2'd2)) state_s = WR_FETCH;
        else                               state_s = WR_CMD;
      end
      WR_FETCH: begin
        if (fetch_r) state_s = WR_DATA;
        else         state_s = WR_FETCH;
      end
      WR_DATA: begin
        if (!done_s)           state_s = WR_DATA;
        else if (!col_last_s)  state_s = WR_FETCH;
        else if (!page_last_s) state_s = WR_CMD;
        else                   state_s = WR_IDLE;
      end
      default: state_s = WR_IDLE;
    endcase
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    page_s    = page_r;
    col_s     = col_r;
    cmd_idx_s = cmd_idx_r;
    fetch_s   = fetch_r;
    addr_s    = addr_r;
    send_s    = send_r;
    data_s    = data_r;
    dc_s      = dc_r;
    fd_s      = 1'b0;
    case (state_r)
      WR_IDLE: begin
        if (start) begin
          page_s    = '0;
          cmd_idx_s = 2'd0;
          send_s    = 1'b1;
          data_s    = page_cmd(8'h00);
          dc_s      = 1'b0;
        end else begin
          send_s = 1'b0;
        end
      end
      WR_CMD: begin
        if (done_s) begin
          case (cmd_idx_r)
            2'd0: begin
              cmd_idx_s = 2'd1;
              data_s    = CMD_COL_LO;
            end
            2'd1: begin
              cmd_idx_s = 2'd2;
              data_s    = CMD_COL_HI;
            end
            default: begin
              col_s   = '0;
              addr_s  = AW'(page_r) * AW'(COLS);
              send_s  = 1'b0;
              fetch_s = 1'b0;
            end
          endcase
        end else begin
          send_s = 1'b1;
        end
      end
      WR_FETCH: begin
        // Address was presented on entry; data is valid in the second cycle.
        fetch_s = ~fetch_r;
        if (fetch_r) begin
          data_s = fb_data;
          send_s = 1'b1;
          dc_s   = 1'b1;
        end else begin
          send_s = 1'b0;
        end
      end
      WR_DATA: begin
        if (!done_s) begin
          send_s = 1'b1;
        end else if (!col_last_s) begin
          col_s   = col_r + CW'(1);
          addr_s  = addr_r + AW'(1);
          send_s  = 1'b0;
          fetch_s = 1'b0;
        end else if (!page_last_s) begin
          page_s    = page_inc_s;
          cmd_idx_s = 2'd0;
          send_s    = 1'b1;
          data_s    = page_cmd(8'(page_inc_s));
          dc_s      = 1'b0;
        end else begin
          send_s = 1'b0;
          fd_s   = 1'b1;
        end
      end
      default: begin
        send_s = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/oled_ctrl.sv
// SSD1306 top sequencer: power-up timing, oled_init pass-through,
// refresh latch and arbitration of the single SPI byte sender.
module oled_ctrl
  import oled_pkg::*;
#(
  parameter int VDD_DLY  = 100_000,
  parameter int RST_LOW  = 300,
  parameter int RST_REC  = 300,
  parameter int VBAT_DLY = 10_000_000,
  parameter int PAGES    = DEF_PAGES,
  parameter int COLS     = DEF_COLS,
  localparam int AW = $clog2(PAGES * COLS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          refresh_req,
  output logic          ready,
  output logic          busy,
  output logic          frame_done,
  input  logic          init_spi_send,
  input  logic [7:0]    init_spi_data,
  input  logic          init_done,
  output logic          init_send_done,
  output logic          init_reset_n,
  output logic [AW-1:0] fb_addr,
  input  logic [7:0]    fb_data,
  output logic          spi_send,
  output logic [7:0]    spi_data,
  output logic          spi_dc,
  input  logic          spi_send_done,
  output logic          oled_vdd_n,
  output logic          oled_vbat_n,
  output logic          oled_res_n
);

  localparam logic [DLY_W-1:0] VDD_LD  = DLY_W'(VDD_DLY - 1);
  localparam logic [DLY_W-1:0] RSTL_LD = DLY_W'(RST_LOW - 1);
  localparam logic [DLY_W-1:0] RSTR_LD = DLY_W'(RST_REC - 1);
  localparam logic [DLY_W-1:0] VBAT_LD = DLY_W'(VBAT_DLY - 1);

  oled_state_e      state_r, state_s;
  logic [DLY_W-1:0] cnt_r, cnt_s;
  logic             pend_r, pend_s;
  logic             vdd_n_r, vdd_n_s, vbat_n_r, vbat_n_s, res_n_r, res_n_s;
  logic             init_rst_n_r, init_rst_n_s;
  logic             ready_r, ready_s, busy_r, busy_s;
  logic             cnt_zero_s, start_s, in_init_s, wr_done_in_s, wr_last_s;
  logic             wr_send_s, wr_dc_s;
  logic [7:0]       wr_data_s;

  assign cnt_zero_s   = (cnt_r == {DLY_W{1'b0}});
  assign start_s      = (state_r == ST_IDLE) & pend_r;
  assign in_init_s    = (state_r == ST_INIT);
  assign wr_done_in_s = spi_send_done & (state_r == ST_FRAME);

  oled_frame_writer #(
    .PAGES (PAGES),
    .COLS  (COLS)
  ) u_writer (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start_s),
    .spi_send_done (wr_done_in_s),
    .fb_data       (fb_data),
    .fb_addr       (fb_addr),
    .spi_send      (wr_send_s),
    .spi_data      (wr_data_s),
    .spi_dc        (wr_dc_s),
    .frame_done    (frame_done),
    .last_done     (wr_last_s)
  );

  // oled_init owns the sender only while in INIT; this path is combinational.
  assign spi_send       = in_init_s ? init_spi_send : wr_send_s;
  assign spi_data       = in_init_s ? init_spi_data : wr_data_s;
  assign spi_dc         = in_init_s ? 1'b0 : wr_dc_s;
  assign init_send_done = in_init_s & spi_send_done;

  assign oled_vdd_n   = vdd_n_r;
  assign oled_vbat_n  = vbat_n_r;
  assign oled_res_n   = res_n_r;
  assign init_reset_n = init_rst_n_r;
  assign ready        = ready_r;
  assign busy         = busy_r;

  // State register, delay counter, refresh latch and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_VDD_WAIT;
      cnt_r        <= VDD_LD;
      pend_r       <= 1'b0;
      vdd_n_r      <= 1'b1;
      vbat_n_r     <= 1'b1;
      res_n_r      <= 1'b1;
      init_rst_n_r <= 1'b0;
      ready_r      <= 1'b0;
      busy_r       <= 1'b1;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      pend_r       <= pend_s;
      vdd_n_r      <= vdd_n_s;
      vbat_n_r     <= vbat_n_s;
      res_n_r      <= res_n_s;
      init_rst_n_r <= init_rst_n_s;
      ready_r      <= ready_s;
      busy_r       <= busy_s;
    end
  end

  // Next-state selection through the power-up sequence and frame requests.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_VDD_WAIT: begin
        if (cnt_zero_s) state_s = ST_RST_LOW;
        else            state_s = ST_VDD_WAIT;
      end
      ST_RST_LOW: begin
        if (cnt_zero_s) state_s = ST_RST_REC;
        else            state_s = ST_RST_LOW;
      end
      ST_RST_REC: begin
        if (cnt_zero_s) state_s = ST_VBAT_WAIT;
        else            state_s = ST_RST_REC;
      end
      ST_VBAT_WAIT: begin
        if (cnt_zero_s) state_s = ST_INIT;
        else            state_s = ST_VBAT_WAIT;
      end
      ST_INIT: begin
        if (init_done) state_s = ST_IDLE;
        else           state_s = ST_INIT;
      end
      ST_IDLE: begin
        if (pend_r) state_s = ST_FRAME;
        else        state_s = ST_IDLE;
      end
      ST_FRAME: begin
        if (wr_last_s) state_s = ST_IDLE;
        else           state_s = ST_FRAME;
      end
      default: state_s = ST_VDD_WAIT;
    endcase
  end

  // Next values of the counter, latch and outputs, derived from the next state
  // so each registered pin changes on the same edge as the state.
  always_comb begin
    cnt_s = cnt_r;
    if (state_s != state_r) begin
      case (state_s)
        ST_RST_LOW:   cnt_s = RSTL_LD;
        ST_RST_REC:   cnt_s = RSTR_LD;
        ST_VBAT_WAIT: cnt_s = VBAT_LD;
        default:      cnt_s = {DLY_W{1'b0}};
      endcase
    end else if (!cnt_zero_s) begin
      cnt_s = cnt_r - DLY_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
    // A request arriving in the same cycle a frame starts re-arms the latch.
    pend_s       = refresh_req | (pend_r & ~start_s);
    vdd_n_s      = 1'b0;
    vbat_n_s     = vbat_n_r & (state_s != ST_VBAT_WAIT);
    res_n_s      = (state_s != ST_RST_LOW);
    init_rst_n_s = init_rst_n_r | (state_s == ST_INIT);
    ready_s      = ready_r | (state_s == ST_IDLE);
    busy_s       = (state_s != ST_IDLE);
  end

endmodule

// File: tb/tb_oled_ctrl.sv
// Directed bench for oled_ctrl with a behavioural sender, init block and
// framebuffer around it.
module tb_oled_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, refresh_req;
  logic       ready, busy, frame_done;
  logic       init_spi_send = 1'b0;
  logic [7:0] init_spi_data = 8'h00;
  logic       init_done = 1'b0;
  logic       init_send_done, init_reset_n;
  logic [8:0] fb_addr;
  logic [7:0] fb_data = 8'h00;
  logic       spi_send, spi_dc, spi_send_done;
  logic [7:0] spi_data;
  logic       oled_vdd_n, oled_vbat_n, oled_res_n;

  logic       model_done = 1'b0;
  logic       stray_done;
  logic       sbusy = 1'b0;
  logic [7:0] sdata = 8'h00;
  logic       sdc = 1'b0;
  int         scnt = 0;
  int         low_cnt = 0;
  int         stab_err = 0;
  int         fd_cnt = 0;
  int         init_idx = 0;
  logic [8:0] cap_q[$];
  int         gap_q[$];
  logic [7:0] init_tbl [11] = '{8'hAE, 8'hD5, 8'h80, 8'h8D, 8'h14, 8'h81,
                                8'hCF, 8'hD9, 8'hF1, 8'hA0, 8'hAF};

  int n_chk = 0;
  int n_fail = 0;
  int n, fd0;

  assign spi_send_done = model_done | stray_done;

  oled_ctrl #(
    .VDD_DLY  (10),
    .RST_LOW  (3),
    .RST_REC  (3),
    .VBAT_DLY (20),
    .PAGES    (4),
    .COLS     (128)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .refresh_req    (refresh_req),
    .ready          (ready),
    .busy           (busy),
    .frame_done     (frame_done),
    .init_spi_send  (init_spi_send),
    .init_spi_data  (init_spi_data),
    .init_done      (init_done),
    .init_send_done (init_send_done),
    .init_reset_n   (init_reset_n),
    .fb_addr        (fb_addr),
    .fb_data        (fb_data),
    .spi_send       (spi_send),
    .spi_data       (spi_data),
    .spi_dc         (spi_dc),
    .spi_send_done  (spi_send_done),
    .oled_vdd_n     (oled_vdd_n),
    .oled_vbat_n    (oled_vbat_n),
    .oled_res_n     (oled_res_n)
  );

  always #5 clk = ~clk;

  // Framebuffer: content is the low address byte, one-cycle read latency.
  always @(posedge clk) fb_data <= fb_addr[7:0];

  // Count cycles with frame_done high.
  always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

  // SPI sender: sample a byte, pulse done four cycles later, log byte and idle gap.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sbusy      <= 1'b0;
      model_done <= 1'b0;
      scnt       <= 0;
      low_cnt    <= 0;
    end else if (!sbusy) begin
      model_done <= 1'b0;
      if (spi_send === 1'b1) begin
        sbusy <= 1'b1;
        scnt  <= 0;
        sdata <= spi_data;
        sdc   <= spi_dc;
        cap_q.push_back({spi_dc, spi_data});
        gap_q.push_back(low_cnt);
        low_cnt <= 0;
      end else begin
        low_cnt <= low_cnt + 1;
      end
    end else begin
      if (spi_send !== 1'b1 || spi_data !== sdata || spi_dc !== sdc) stab_err <= stab_err + 1;
      if (model_done) begin
        model_done <= 1'b0;
        sbusy      <= 1'b0;
      end else begin
        scnt <= scnt + 1;
        if (scnt == 3) model_done <= 1'b1;
      end
    end
  end

  // oled_init stand-in: send the command table byte by byte, then raise init_done.
  always @(posedge clk or negedge init_reset_n) begin
    if (!init_reset_n) begin
      init_idx      <= 0;
      init_spi_send <= 1'b0;
      init_spi_data <= 8'h00;
      init_done     <= 1'b0;
    end else if (!init_done) begin
      if (!init_spi_send) begin
        init_spi_send <= 1'b1;
        init_spi_data <= init_tbl[init_idx];
      end else if (init_send_done) begin
        if (init_idx == 10) begin
          init_spi_send <= 1'b0;
          init_done     <= 1'b1;
        end else begin
          init_idx      <= init_idx + 1;
          init_spi_data <= init_tbl[init_idx + 1];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Release reset and check the power-up timing up to ready.
  task automatic power_seq(input bit inject_stray, input bit vbat_req);
    reset_n = 1'b1;
    tick();
    chk("vdd_n_on", 32'(oled_vdd_n), 32'd0);
    n = 1;
    if (inject_stray) begin
      stray_done = 1'b1;
      tick();
      stray_done = 1'b0;
      n = 2;
      chk("stray_spi_send", 32'(spi_send), 32'd0);
    end
    while (oled_res_n !== 1'b0 && n < 200) begin tick(); n++; end
    chk("vdd_to_res_cycles", 32'(n), 32'd10);
    n = 0;
    while (oled_res_n === 1'b0 && n < 200) begin tick(); n++; end
    chk("res_low_cycles", 32'(n), 32'd3);
    n = 0;
    while (oled_vbat_n !== 1'b0 && n < 200) begin tick(); n++; end
    chk("res_to_vbat_cycles", 32'(n), 32'd3);
    n = 0;
    if (vbat_req) begin
      refresh_req = 1'b1;
      tick();
      refresh_req = 1'b0;
      n = 1;
    end
    while (init_reset_n !== 1'b1 && n < 200) begin tick(); n++; end
    chk("vbat_to_init_cycles", 32'(n), 32'd20);
    chk("ready_before_init", 32'(ready), 32'd0);
    n = 0;
    while (ready !== 1'b1 && n < 5000) begin tick(); n++; end
    chk("ready_timeout", 32'(n < 5000), 32'd1);
  endtask

  task automatic wait_frames(input int cnt);
    n = 0;
    while (!((fd_cnt - fd0) >= cnt && busy === 1'b0) && n < 20000) begin tick(); n++; end
    chk("frame_timeout", 32'(n < 20000), 32'd1);
  endtask

  // Compare a logged frame against the expected byte stream and gaps.
  task automatic check_frame(input int base);
    int p, k, eg;
    logic [8:0] exp;
    if (cap_q.size() >= base + 524) begin
      for (int i = 0; i < 524; i++) begin
        p = i / 131;
        k = i % 131;
        if (k == 0)      exp = {1'b0, 8'hB0 | 8'(p)};
        else if (k == 1) exp = 9'h000;
        else if (k == 2) exp = 9'h010;
        else             exp = {1'b1, 8'(p * 128 + k - 3)};
        eg = (k >= 3) ? 2 : 0;
        chk($sformatf("frame_byte[%0d]", base + i), 32'(cap_q[base + i]), 32'(exp));
        if (i != 0) chk($sformatf("byte_gap[%0d]", base + i), 32'(gap_q[base + i]), 32'(eg));
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    refresh_req = 1'b0;
    stray_done  = 1'b0;
    tick();
    chk("rst_vdd_n", 32'(oled_vdd_n), 32'd1);
    chk("rst_vbat_n", 32'(oled_vbat_n), 32'd1);
    chk("rst_res_n", 32'(oled_res_n), 32'd1);
    chk("rst_init_reset_n", 32'(init_reset_n), 32'd0);
    chk("rst_spi_send", 32'(spi_send), 32'd0);
    chk("rst_spi_data", 32'(spi_data), 32'h00);
    chk("rst_spi_dc", 32'(spi_dc), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    tick();
    tick();

    // Power-up and init.
    cap_q.delete();
    gap_q.delete();
    power_seq(1'b0, 1'b0);
    chk("init_byte_count", 32'(cap_q.size()), 32'd11);
    if (cap_q.size() >= 11)
      for (int i = 0; i < 11; i++)
        chk($sformatf("init_byte[%0d]", i), 32'(cap_q[i]), 32'({1'b0, init_tbl[i]}));
    chk("ready_after_init", 32'(ready), 32'd1);
    chk("busy_after_init", 32'(busy), 32'd0);

    // One frame from a single request pulse.
    tick();
    cap_q.delete();
    gap_q.delete();
    fd0 = fd_cnt;
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    wait_frames(1);
    repeat (50) tick();
    chk("frame1_done_pulses", 32'(fd_cnt - fd0), 32'd1);
    chk("frame1_byte_count", 32'(cap_q.size()), 32'd524);
    check_frame(0);

    // Three requests during a frame give exactly one more frame.
    cap_q.delete();
    gap_q.delete();
    fd0 = fd_cnt;
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      repeat (100) tick();
      refresh_req = 1'b1;
      tick();
      refresh_req = 1'b0;
    end
    wait_frames(2);
    repeat (300) tick();
    chk("multi_req_frames", 32'(fd_cnt - fd0), 32'd2);
    chk("multi_req_busy", 32'(busy), 32'd0);
    chk("multi_req_bytes", 32'(cap_q.size()), 32'd1048);
    check_frame(0);
    check_frame(524);

    // Asynchronous reset in the middle of a data byte.
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    n = 0;
    while (!(spi_send === 1'b1 && spi_dc === 1'b1) && n < 2000) begin tick(); n++; end
    chk("data_phase_timeout", 32'(n < 2000), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_spi_send", 32'(spi_send), 32'd0);
    chk("midrst_vdd_n", 32'(oled_vdd_n), 32'd1);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_init_reset_n", 32'(init_reset_n), 32'd0);
    chk("midrst_fb_addr", 32'(fb_addr), 32'd0);
    repeat (3) tick();

    // Restart with a stray done and a request pending since VBAT_WAIT.
    power_seq(1'b1, 1'b1);
    chk("pending_ready_busy", 32'(busy), 32'd0);
    cap_q.delete();
    gap_q.delete();
    fd0 = fd_cnt;
    tick();
    chk("pending_start_busy", 32'(busy), 32'd1);
    chk("pending_start_send", 32'(spi_send), 32'd1);
    chk("pending_start_data", 32'(spi_data), 32'hB0);
    chk("pending_start_dc", 32'(spi_dc), 32'd0);
    n = 0;
    while (!(spi_send === 1'b0 && spi_dc === 1'b1) && n < 2000) begin tick(); n++; end
    chk("fetch_phase_timeout", 32'(n < 2000), 32'd1);
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    wait_frames(1);
    repeat (50) tick();
    chk("restart_frames", 32'(fd_cnt - fd0), 32'd1);
    chk("restart_bytes", 32'(cap_q.size()), 32'd524);
    check_frame(0);
    chk("handshake_stability", 32'(stab_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
